// File: rtl/sprite_frame_renderer_pkg.sv
// sprite_frame_renderer_pkg: shared FSM encoding, screen geometry and palette for the sprite compositor
package sprite_frame_renderer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ERASE, S_LATCH, S_DRAW, S_DONE} state_t;
  localparam int CG_SCREEN_W = 160;
  localparam int CG_SCREEN_H = 120;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] CYAN  = 3'b011;
  localparam logic [2:0] RED   = 3'b100;
endpackage

// File: rtl/sprite_frame_renderer_rect_sweeper.sv
// sprite_frame_renderer_rect_sweeper: walks a rectangle one pixel per step, dx fastest, flags off-screen pixels
module sprite_frame_renderer_rect_sweeper #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W:0]   px_o,
  output logic [Y_W:0]   py_o,
  output logic           clip_o,
  output logic           last_o
);
  logic [X_W-1:0] dx_q, dx_d;
  logic [Y_W-1:0] dy_q, dy_d;
  // counters wrap to zero after the last pixel, so the next rectangle starts clean
  always_comb begin
    last_o = dx_q == w_i && dy_q == h_i;
    dx_d   = !step_i ? dx_q : (dx_q == w_i) ? '0 : dx_q + 1'b1;
    dy_d   = (!step_i || dx_q != w_i) ? dy_q : last_o ? '0 : dy_q + 1'b1;
    px_o   = {1'b0, x0_i} + {1'b0, dx_q};
    py_o   = {1'b0, y0_i} + {1'b0, dy_q};
    clip_o = px_o >= (X_W+1)'(SCREEN_W) || py_o >= (Y_W+1)'(SCREEN_H);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
endmodule

// File: rtl/sprite_frame_renderer.sv
// sprite_frame_renderer: per-frame erase/latch/redraw of N sprites plus full-screen clear, one pixel per clock
module sprite_frame_renderer
  import sprite_frame_renderer_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SIZE_W    = 4,
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = CG_SCREEN_W,
  parameter int SCREEN_H  = CG_SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                            CLOCK_50,
  input  logic                            resetn,
  input  logic                            frame_tick,
  input  logic                            clear_req,
  input  logic [N_SPRITES-1:0]            spr_en,
  input  logic [N_SPRITES*X_W-1:0]        spr_x,
  input  logic [N_SPRITES*Y_W-1:0]        spr_y,
  input  logic [N_SPRITES*SIZE_W-1:0]     spr_w,
  input  logic [N_SPRITES*SIZE_W-1:0]     spr_h,
  input  logic [N_SPRITES*COLOUR_W-1:0]   spr_colour,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            plot,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            frame_overrun
);
  localparam int IDX_W = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   clear_pending_q;
  logic [N_SPRITES-1:0]   valid_q;
  logic [X_W-1:0]         sx_q [N_SPRITES];
  logic [Y_W-1:0]         sy_q [N_SPRITES];
  logic [SIZE_W-1:0]      sw_q [N_SPRITES];
  logic [SIZE_W-1:0]      sh_q [N_SPRITES];
  logic [COLOUR_W-1:0]    sc_q [N_SPRITES];
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [COLOUR_W-1:0]    colour_q;
  logic                   plot_q, busy_q, done_q, overrun_q;

  logic                   sweeping, cur_valid, step, last_idx, clip, last;
  logic [X_W-1:0]         gx, gw;
  logic [Y_W-1:0]         gy, gh;
  logic [X_W:0]           px;
  logic [Y_W:0]           py;
  logic [COLOUR_W-1:0]    pix_colour;

  // CLEAR reuses the sweeper as one screen-sized rectangle at the origin
  always_comb begin
    sweeping   = state_q == S_ERASE || state_q == S_DRAW;
    cur_valid  = valid_q[idx_q];
    step       = state_q == S_CLEAR || (sweeping && cur_valid);
    last_idx   = idx_q == IDX_W'(N_SPRITES-1);
    gx         = state_q == S_CLEAR ? '0 : sx_q[idx_q];
    gy         = state_q == S_CLEAR ? '0 : sy_q[idx_q];
    gw         = state_q == S_CLEAR ? X_W'(SCREEN_W-1) : X_W'(sw_q[idx_q]);
    gh         = state_q == S_CLEAR ? Y_W'(SCREEN_H-1) : Y_W'(sh_q[idx_q]);
    pix_colour = state_q == S_DRAW ? sc_q[idx_q] : BG_COLOUR;
  end

  sprite_frame_renderer_rect_sweeper #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) u_sweep (
    .clk(CLOCK_50), .rst_n(resetn), .step_i(step),
    .x0_i(gx), .y0_i(gy), .w_i(gw), .h_i(gh),
    .px_o(px), .py_o(py), .clip_o(clip), .last_o(last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      clear_pending_q <= 1'b1;
      valid_q         <= '0;
      x_q             <= '0;
      y_q             <= '0;
      colour_q        <= '0;
      plot_q          <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      busy_q    <= state_q != S_IDLE;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= frame_tick && state_q != S_IDLE;
      case (state_q)
        S_IDLE: begin
          if (clear_pending_q || clear_req) begin
            state_q         <= S_CLEAR;
            clear_pending_q <= 1'b0;
            valid_q         <= '0;
            overrun_q       <= frame_tick;
          end else if (frame_tick) begin
            state_q <= S_ERASE;
            idx_q   <= '0;
          end
        end
        S_CLEAR: begin
          plot_q   <= 1'b1;
          x_q      <= px[X_W-1:0];
          y_q      <= py[Y_W-1:0];
          colour_q <= BG_COLOUR;
          if (last) state_q <= S_IDLE;
        end
        S_ERASE, S_DRAW: begin
          if (cur_valid && !clip) begin
            plot_q   <= 1'b1;
            x_q      <= px[X_W-1:0];
            y_q      <= py[Y_W-1:0];
            colour_q <= pix_colour;
          end
          // a disabled sprite costs exactly one idle cycle
          if (!cur_valid || last) begin
            idx_q <= last_idx ? '0 : idx_q + 1'b1;
            if (last_idx) state_q <= state_q == S_ERASE ? S_LATCH : S_DONE;
          end
        end
        S_LATCH: begin
          valid_q <= spr_en;
          state_q <= S_DRAW;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_LATCH) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sx_q[i] <= spr_x[i*X_W +: X_W];
        sy_q[i] <= spr_y[i*Y_W +: Y_W];
        sw_q[i] <= spr_w[i*SIZE_W +: SIZE_W];
        sh_q[i] <= spr_h[i*SIZE_W +: SIZE_W];
        sc_q[i] <= spr_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign colour        = colour_q;
  assign plot          = plot_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_overrun = overrun_q;
endmodule
